// File: rtl/alu_cmd_issuer_pkg.sv
// Shared ALU definitions: op codes, operand width default and issuer FSM states.
// Both the ALU and the command issuer import this package.
package alu_cmd_issuer_pkg;

    localparam int ALU_OP_W          = 2;
    localparam int ALU_WIDTH_DEFAULT = 32;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_OP_ADD = 2'b00,
        ALU_OP_SUB = 2'b01,
        ALU_OP_AND = 2'b10,
        ALU_OP_OR  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10
    } issuer_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with registered full/empty flags.
// A push is ignored while full and a pop is ignored while empty.
module alu_cmd_fifo #(
    parameter int WIDTH = 66,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic             r_full;
    logic             r_empty;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push && !r_full;
    assign w_do_pop  = i_pop && !r_empty;

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_count_next = r_count;
        if (w_do_push && !w_do_pop) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (w_do_pop && !w_do_push) begin
            w_count_next = r_count - CNT_W'(1);
        end
    end

    // NOTE: storage is not reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= w_count_next;
            r_full  <= (w_count_next == CNT_W'(DEPTH));
            r_empty <= (w_count_next == '0);
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/alu_cmd_issuer.sv
// Issues buffered ALU commands one at a time and returns each registered result
// with an issue-order tag over a valid/ready response port.
module alu_cmd_issuer
    import alu_cmd_issuer_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH_DEFAULT,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ALU_OP_W-1:0] cmd_op,
    input  logic [WIDTH-1:0]    cmd_a,
    input  logic [WIDTH-1:0]    cmd_b,
    output logic [ALU_OP_W-1:0] alu_ctrl,
    output logic [WIDTH-1:0]    alu_a,
    output logic [WIDTH-1:0]    alu_b,
    input  logic [WIDTH-1:0]    alu_result,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WIDTH-1:0]    rsp_data,
    output logic                rsp_zero,
    output logic [TAG_W-1:0]    rsp_tag
);

    localparam int FIFO_W = ALU_OP_W + 2 * WIDTH;

    issuer_state_e       r_state;
    issuer_state_e       w_state_next;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic [FIFO_W-1:0]   w_fifo_data;
    logic [ALU_OP_W-1:0] r_alu_ctrl;
    logic [WIDTH-1:0]    r_alu_a;
    logic [WIDTH-1:0]    r_alu_b;
    logic                r_rsp_valid;
    logic [WIDTH-1:0]    r_rsp_data;
    logic                r_rsp_zero;
    logic [TAG_W-1:0]    r_rsp_tag;
    logic [TAG_W-1:0]    r_tag_cnt;

    assign cmd_ready = !w_full;
    assign w_push    = cmd_valid && !w_full;

    alu_cmd_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  ({cmd_op, cmd_a, cmd_b}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // The next command is popped in the same edge the current response is accepted.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: w_state_next = ST_WAIT;
            ST_WAIT: begin
                if (rsp_ready) begin
                    w_pop        = !w_empty;
                    w_state_next = w_empty ? ST_IDLE : ST_ISSUE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_alu_ctrl  <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_zero  <= 1'b0;
            r_rsp_tag   <= '0;
            r_tag_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_pop) begin
                {r_alu_ctrl, r_alu_a, r_alu_b} <= w_fifo_data;
            end
            if (r_state == ST_ISSUE) begin
                r_rsp_data  <= alu_result;
                r_rsp_zero  <= (alu_result == '0);
                r_rsp_tag   <= r_tag_cnt;
                r_tag_cnt   <= r_tag_cnt + TAG_W'(1);
                r_rsp_valid <= 1'b1;
            end else if (r_state == ST_WAIT && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign alu_ctrl  = r_alu_ctrl;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_zero  = r_rsp_zero;
    assign rsp_tag   = r_rsp_tag;

endmodule
